// File: rtl/agnus_dram_pkg.sv
// agnus_dram_pkg: shared types, default timing and address-mux helpers for
// the Agnus-style DRAM cycle generator and its verification models.
//   state_t      - cycle FSM states
//   addr_dec_t   - decoded row/column/RAS-select for one request
//   req_flags_t  - captured request qualifiers
//   row_addr()   - DRA value during the row phase
//   col_addr()   - DRA value during the column phase
package agnus_dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RAS,
    ST_CAS,
    ST_PRE
  } state_t;

  // Default timing, in CLK80 cycles (12.5 ns).
  localparam int DEF_T_ASR = 1;
  localparam int DEF_T_RCD = 4;
  localparam int DEF_T_CAS = 8;
  localparam int DEF_T_RP  = 6;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic [1:0] ras_sel;  // bit0 -> RAS0n, bit1 -> RAS1n (active-high select)
  } addr_dec_t;

  typedef struct packed {
    logic write;
    logic uds;
    logic lds;
    logic refresh;
  } req_flags_t;

  // a holds word address A[20:1], so A<n> sits at a[n-1].
  function automatic logic [9:0] row_addr(input logic [19:0] a, input logic mb2);
    return {(mb2 ? a[18] : 1'b0), a[16:8]};
  endfunction

  function automatic logic [9:0] col_addr(input logic [19:0] a, input logic mb2);
    return {(mb2 ? a[19] : 1'b0), a[17], a[7:0]};
  endfunction

endpackage

// File: rtl/agnus_addr_mux.sv
// agnus_addr_mux: combinational row/column/RAS-select decode.
//   i_a        - word address A[20:1]
//   i_refresh  - RAS-only refresh (both banks)
//   o_dec      - row, column and RAS select
module agnus_addr_mux
  import agnus_dram_pkg::*;
#(
  parameter bit AGNUS_2MB = 1'b0
) (
  input  logic [19:0] i_a,
  input  logic        i_refresh,
  output addr_dec_t   o_dec
);

  always_comb begin
    o_dec.row = row_addr(i_a, AGNUS_2MB);
    o_dec.col = col_addr(i_a, AGNUS_2MB);
    if (i_refresh)      o_dec.ras_sel = 2'b11;
    else if (AGNUS_2MB) o_dec.ras_sel = 2'b01;
    else                o_dec.ras_sel = i_a[18] ? 2'b10 : 2'b01;  // A19 picks bank
  end

endmodule

// File: rtl/agnus_dram_cycle_gen.sv
// agnus_dram_cycle_gen: turns a valid/ready request into Agnus-style chip-RAM
// strobes, including RAS-only refresh. All outputs are registered.
//   CLK80        - clock (12.5 ns), rising edge
//   REFRESH_RST  - async active-high reset
//   REQ_VALID/REQ_READY - request handshake, READY high only in IDLE
//   REQ_A, REQ_WRITE, REQ_UDS, REQ_LDS, REQ_REFRESH - request fields
//   DONE         - one-cycle pulse when RAS is released
//   DRA          - multiplexed DRAM address
//   RAS0n, RAS1n, CASLn, CASUn, AWEn, DBRn - active-low strobes
module agnus_dram_cycle_gen
  import agnus_dram_pkg::*;
#(
  parameter int T_ASR     = DEF_T_ASR,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_CAS     = DEF_T_CAS,
  parameter int T_RP      = DEF_T_RP,
  parameter bit AGNUS_2MB = 1'b0
) (
  input  logic        CLK80,
  input  logic        REFRESH_RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [19:0] REQ_A,
  input  logic        REQ_WRITE,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic        REQ_REFRESH,
  output logic        DONE,
  output logic [9:0]  DRA,
  output logic        RAS0n,
  output logic        RAS1n,
  output logic        CASLn,
  output logic        CASUn,
  output logic        AWEn,
  output logic        DBRn
);

  // Phase boundaries, as counter values (t=0 is the first cycle after accept).
  localparam int T_COL_I = T_ASR + 2;
  localparam int T_CAS_I = T_ASR + T_RCD;
  localparam int T_PRE_I = T_CAS_I + T_CAS;
  localparam int T_END_I = T_PRE_I + T_RP;

  localparam logic [CNT_W-1:0] C_RAS = CNT_W'(T_ASR);
  localparam logic [CNT_W-1:0] C_COL = CNT_W'(T_COL_I);
  localparam logic [CNT_W-1:0] C_CAS = CNT_W'(T_CAS_I);
  localparam logic [CNT_W-1:0] C_PRE = CNT_W'(T_PRE_I);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(T_END_I);

  if (T_ASR < 1 || T_RCD < 3 || T_CAS < 1 || T_RP < 1) begin : g_bad_min
    $error("agnus_dram_cycle_gen: timing parameter below minimum");
  end
  if (T_END_I > CNT_MAX) begin : g_bad_sum
    $error("agnus_dram_cycle_gen: timing sum exceeds 8-bit counter");
  end

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_t, w_t_nxt, w_t_inc;
  logic             w_accept;

  addr_dec_t  w_dec, r_dec, w_cur_dec;
  req_flags_t w_flags, r_flags, w_cur_flags;

  logic       r_ready, r_done, r_ras0n, r_ras1n, r_casln, r_casun, r_awen, r_dbrn;
  logic [9:0] r_dra;
  logic       w_ready_nxt, w_done_nxt, w_ras0n_nxt, w_ras1n_nxt;
  logic       w_casln_nxt, w_casun_nxt, w_awen_nxt, w_dbrn_nxt;
  logic [9:0] w_dra_nxt;

  agnus_addr_mux #(.AGNUS_2MB(AGNUS_2MB)) u_mux (
    .i_a       (REQ_A),
    .i_refresh (REQ_REFRESH),
    .o_dec     (w_dec)
  );

  assign w_flags  = '{write: REQ_WRITE, uds: REQ_UDS, lds: REQ_LDS, refresh: REQ_REFRESH};
  assign w_accept = REQ_VALID && (r_state == ST_IDLE);
  assign w_t_inc  = r_t + 1'b1;

  // On the accept edge the request registers are not loaded yet, so the
  // output decode looks straight at the incoming request.
  assign w_cur_dec   = w_accept ? w_dec   : r_dec;
  assign w_cur_flags = w_accept ? w_flags : r_flags;

  // State / counter register
  always_ff @(posedge CLK80 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Request capture, held for the whole cycle
  always_ff @(posedge CLK80 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      r_dec   <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_dec   <= w_dec;
      r_flags <= w_flags;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = w_t_inc;
    unique case (r_state)
      ST_IDLE: begin
        w_t_nxt = '0;
        if (REQ_VALID) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: if (w_t_inc == C_RAS) w_state_nxt = ST_RAS;
      ST_RAS:  if (w_t_inc == C_CAS) w_state_nxt = ST_CAS;
      ST_CAS:  if (w_t_inc == C_PRE) w_state_nxt = ST_PRE;
      ST_PRE: begin
        if (w_t_inc == C_END) begin
          w_state_nxt = ST_IDLE;
          w_t_nxt     = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_t_nxt     = '0;
      end
    endcase
  end

  // Output decode of the upcoming state; registered below so nothing on
  // REQ_* reaches a pin combinationally.
  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_done_nxt  = 1'b0;
    w_dra_nxt   = r_dra;
    w_ras0n_nxt = 1'b1;
    w_ras1n_nxt = 1'b1;
    w_casln_nxt = 1'b1;
    w_casun_nxt = 1'b1;
    w_awen_nxt  = 1'b1;
    w_dbrn_nxt  = 1'b1;
    unique case (w_state_nxt)
      ST_ADDR: begin
        w_dbrn_nxt = 1'b0;
        w_dra_nxt  = w_cur_dec.row;
        w_awen_nxt = ~(w_cur_flags.write & ~w_cur_flags.refresh);
      end
      ST_RAS, ST_CAS: begin
        w_dbrn_nxt  = 1'b0;
        w_awen_nxt  = ~(w_cur_flags.write & ~w_cur_flags.refresh);
        w_ras0n_nxt = ~w_cur_dec.ras_sel[0];
        w_ras1n_nxt = ~w_cur_dec.ras_sel[1];
        // Refresh keeps the row on DRA for the whole cycle.
        if (!w_cur_flags.refresh && w_t_nxt >= C_COL) w_dra_nxt = w_cur_dec.col;
        if (w_state_nxt == ST_CAS && !w_cur_flags.refresh) begin
          w_casun_nxt = ~w_cur_flags.uds;
          w_casln_nxt = ~w_cur_flags.lds;
        end
      end
      ST_PRE:  w_done_nxt = (r_state == ST_CAS);
      default: ;
    endcase
  end

  always_ff @(posedge CLK80 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_dra   <= '0;
      r_ras0n <= 1'b1;
      r_ras1n <= 1'b1;
      r_casln <= 1'b1;
      r_casun <= 1'b1;
      r_awen  <= 1'b1;
      r_dbrn  <= 1'b1;
    end else begin
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_dra   <= w_dra_nxt;
      r_ras0n <= w_ras0n_nxt;
      r_ras1n <= w_ras1n_nxt;
      r_casln <= w_casln_nxt;
      r_casun <= w_casun_nxt;
      r_awen  <= w_awen_nxt;
      r_dbrn  <= w_dbrn_nxt;
    end
  end

  assign REQ_READY = r_ready;
  assign DONE      = r_done;
  assign DRA       = r_dra;
  assign RAS0n     = r_ras0n;
  assign RAS1n     = r_ras1n;
  assign CASLn     = r_casln;
  assign CASUn     = r_casun;
  assign AWEn      = r_awen;
  assign DBRn      = r_dbrn;

endmodule

// File: tb/tb_agnus_dram_cycle_gen.sv
// Directed bench: one 1MB-mode instance (index 0) and one 2MB-mode instance
// (index 1) share the request inputs; outputs are sampled on the falling edge.
module tb_agnus_dram_cycle_gen;

  logic        CLK80 = 1'b0;
  logic        REFRESH_RST;
  logic        REQ_VALID;
  logic [19:0] REQ_A;
  logic        REQ_WRITE, REQ_UDS, REQ_LDS, REQ_REFRESH;

  logic [1:0]      rdy, done, ras0n, ras1n, casln, casun, awen, dbrn;
  logic [1:0][9:0] dra;

  int vec  = 0;
  int miss = 0;

  // Per-cycle history, index [dut][t]
  logic [9:0] h_dra [0:1][0:23];
  logic [7:0] h_sig [0:1][0:23];  // {ras0n,ras1n,casun,casln,awen,dbrn,done,rdy}

  localparam logic [19:0] ADDR_A = {1'b0, 1'b1, 1'b1, 9'h155, 8'hA5};

  always #6 CLK80 = ~CLK80;

  agnus_dram_cycle_gen #(.AGNUS_2MB(1'b0)) u_dut1 (
    .CLK80(CLK80), .REFRESH_RST(REFRESH_RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy[0]),
    .REQ_A(REQ_A), .REQ_WRITE(REQ_WRITE), .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS),
    .REQ_REFRESH(REQ_REFRESH), .DONE(done[0]), .DRA(dra[0]), .RAS0n(ras0n[0]),
    .RAS1n(ras1n[0]), .CASLn(casln[0]), .CASUn(casun[0]), .AWEn(awen[0]), .DBRn(dbrn[0])
  );

  agnus_dram_cycle_gen #(.AGNUS_2MB(1'b1)) u_dut2 (
    .CLK80(CLK80), .REFRESH_RST(REFRESH_RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy[1]),
    .REQ_A(REQ_A), .REQ_WRITE(REQ_WRITE), .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS),
    .REQ_REFRESH(REQ_REFRESH), .DONE(done[1]), .DRA(dra[1]), .RAS0n(ras0n[1]),
    .RAS1n(ras1n[1]), .CASLn(casln[1]), .CASUn(casun[1]), .AWEn(awen[1]), .DBRn(dbrn[1])
  );

  function automatic logic [7:0] sig_of(input int d);
    return {ras0n[d], ras1n[d], casun[d], casln[d], awen[d], dbrn[d], done[d], rdy[d]};
  endfunction

  function automatic logic in_rng(input int t, input int lo, input int hi);
    return (t >= lo) && (t <= hi);
  endfunction

  // Issue one request and record t=0..20 for both instances.
  task automatic run_req(input logic [19:0] a, input logic wr, input logic uds,
                         input logic lds, input logic rf);
    @(negedge CLK80);
    REQ_A = a; REQ_WRITE = wr; REQ_UDS = uds; REQ_LDS = lds; REQ_REFRESH = rf;
    REQ_VALID = 1'b1;
    vec++;
    if (rdy !== 2'b11) begin
      miss++;
      $display("FAIL ready_before_req: got %b want 11", rdy);
    end
    @(posedge CLK80);
    for (int t = 0; t <= 20; t++) begin
      @(negedge CLK80);
      if (t == 0) REQ_VALID = 1'b0;
      for (int d = 0; d < 2; d++) begin
        h_dra[d][t] = dra[d];
        h_sig[d][t] = sig_of(d);
      end
    end
  endtask

  task automatic test_reset();
    REFRESH_RST = 1'b1;
    REQ_VALID = 1'b0; REQ_A = '0; REQ_WRITE = 1'b0; REQ_UDS = 1'b0;
    REQ_LDS = 1'b0; REQ_REFRESH = 1'b0;
    repeat (3) @(negedge CLK80);
    REFRESH_RST = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK80);
      for (int d = 0; d < 2; d++) begin
        vec++;
        if (sig_of(d) !== 8'b1111_1101 || dra[d] !== 10'h000) begin
          miss++;
          $display("FAIL reset_idle d%0d k%0d: sig=%b dra=%h want sig=11111101 dra=000",
                   d, k, sig_of(d), dra[d]);
        end
      end
    end
  endtask

  task automatic test_2mb_write();
    logic [7:0] exp;
    run_req(ADDR_A, 1'b1, 1'b1, 1'b1, 1'b0);
    vec++;
    if (h_dra[1][0] !== 10'h355) begin miss++; $display("FAIL w2_row_t0: got %h want 355", h_dra[1][0]); end
    vec++;
    if (h_dra[1][2] !== 10'h355) begin miss++; $display("FAIL w2_row_t2: got %h want 355", h_dra[1][2]); end
    vec++;
    if (h_dra[1][3] !== 10'h1A5) begin miss++; $display("FAIL w2_col_t3: got %h want 1a5", h_dra[1][3]); end
    vec++;
    if (h_dra[1][15] !== 10'h1A5) begin miss++; $display("FAIL w2_dra_hold: got %h want 1a5", h_dra[1][15]); end
    for (int t = 0; t <= 20; t++) begin
      exp = {~in_rng(t, 1, 12), 1'b1, ~in_rng(t, 5, 12), ~in_rng(t, 5, 12),
             ~in_rng(t, 0, 12), ~in_rng(t, 0, 12), (t == 13), (t >= 19)};
      vec++;
      if (h_sig[1][t] !== exp) begin
        miss++;
        $display("FAIL w2_strobes t%0d: got %b want %b", t, h_sig[1][t], exp);
      end
    end
  endtask

  task automatic test_1mb_read();
    logic [7:0] exp;
    run_req(ADDR_A, 1'b0, 1'b0, 1'b1, 1'b0);
    vec++;
    if (h_dra[0][0] !== 10'h155) begin miss++; $display("FAIL r1_row_t0: got %h want 155", h_dra[0][0]); end
    vec++;
    if (h_dra[0][3] !== 10'h1A5) begin miss++; $display("FAIL r1_col_t3: got %h want 1a5", h_dra[0][3]); end
    for (int t = 0; t <= 20; t++) begin
      exp = {1'b1, ~in_rng(t, 1, 12), 1'b1, ~in_rng(t, 5, 12),
             1'b1, ~in_rng(t, 0, 12), (t == 13), (t >= 19)};
      vec++;
      if (h_sig[0][t] !== exp) begin
        miss++;
        $display("FAIL r1_strobes t%0d: got %b want %b", t, h_sig[0][t], exp);
      end
    end
    // Same address on the 2MB part still lands on RAS0n.
    vec++;
    if (h_sig[1][6][7:6] !== 2'b01) begin
      miss++;
      $display("FAIL r2_bank_t6: got %b want 01", h_sig[1][6][7:6]);
    end
  endtask

  task automatic test_refresh();
    logic [7:0] exp;
    // Write and byte enables set to show they are ignored on refresh.
    run_req(20'h0ABCD, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int t = 0; t <= 20; t++) begin
      exp = {~in_rng(t, 1, 12), ~in_rng(t, 1, 12), 1'b1, 1'b1,
             1'b1, ~in_rng(t, 0, 12), (t == 13), (t >= 19)};
      vec++;
      if (h_sig[0][t] !== exp || h_dra[0][t] !== 10'h0AB) begin
        miss++;
        $display("FAIL refresh t%0d: sig=%b dra=%h want sig=%b dra=0ab",
                 t, h_sig[0][t], h_dra[0][t], exp);
      end
    end
  endtask

  task automatic test_no_byte_enables();
    logic [7:0] exp;
    run_req(20'h00000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t <= 20; t++) begin
      exp = {~in_rng(t, 1, 12), 1'b1, 1'b1, 1'b1,
             ~in_rng(t, 0, 12), ~in_rng(t, 0, 12), (t == 13), (t >= 19)};
      vec++;
      if (h_sig[1][t] !== exp) begin
        miss++;
        $display("FAIL no_be t%0d: got %b want %b", t, h_sig[1][t], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic h_rdy [0:59];
    logic h_ras [0:59];
    int   acc [0:2];
    int   n;
    @(negedge CLK80);
    REQ_A = ADDR_A; REQ_WRITE = 1'b1; REQ_UDS = 1'b1; REQ_LDS = 1'b1; REQ_REFRESH = 1'b0;
    REQ_VALID = 1'b1;
    for (int k = 0; k < 60; k++) begin
      h_rdy[k] = rdy[0];
      h_ras[k] = ras0n[1];
      if (k == 59) REQ_VALID = 1'b0;
      @(negedge CLK80);
    end
    n = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    for (int k = 0; k < 60; k++)
      if (h_rdy[k] && n < 3) begin acc[n] = k; n++; end
    vec++;
    if (acc[0] !== 0 || acc[1] !== 20 || acc[2] !== 40) begin
      miss++;
      $display("FAIL b2b_accept: got %0d,%0d,%0d want 0,20,40", acc[0], acc[1], acc[2]);
    end
    vec++;
    if (h_ras[2] !== 1'b0 || h_ras[22] !== 1'b0) begin
      miss++;
      $display("FAIL b2b_ras_low: got %b,%b want 0,0", h_ras[2], h_ras[22]);
    end
    for (int k = 14; k <= 21; k++) begin
      vec++;
      if (h_ras[k] !== 1'b1) begin
        miss++;
        $display("FAIL b2b_ras_gap k%0d: got %b want 1", k, h_ras[k]);
      end
    end
    // Let the third cycle drain, bounded.
    n = 0;
    while (rdy[0] !== 1'b1 && n < 40) begin @(negedge CLK80); n++; end
    vec++;
    if (rdy[0] !== 1'b1) begin miss++; $display("FAIL b2b_drain: ready=%b want 1", rdy[0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK80);
    REQ_A = ADDR_A; REQ_WRITE = 1'b1; REQ_UDS = 1'b1; REQ_LDS = 1'b1; REQ_REFRESH = 1'b0;
    REQ_VALID = 1'b1;
    @(posedge CLK80);
    for (int t = 0; t <= 7; t++) begin
      @(negedge CLK80);
      if (t == 0) REQ_VALID = 1'b0;
    end
    vec++;
    if (ras0n[1] !== 1'b0 || awen[1] !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid_active: ras0n=%b awen=%b want 0,0", ras0n[1], awen[1]);
    end
    REFRESH_RST = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      vec++;
      if (sig_of(d) !== 8'b1111_1101) begin
        miss++;
        $display("FAIL rst_mid_strobes d%0d: got %b want 11111101", d, sig_of(d));
      end
    end
    @(negedge CLK80);
    REFRESH_RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK80);
      vec++;
      if (done !== 2'b00 || rdy !== 2'b11) begin
        miss++;
        $display("FAIL rst_mid_after k%0d: done=%b ready=%b want 00,11", k, done, rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_2mb_write();
    test_1mb_read();
    test_refresh();
    test_no_byte_enables();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/agnus_dram_cycle_gen.md
# agnus_dram_cycle_gen

Agnus-side DRAM cycle initiator: turns a single-request valid/ready handshake into Agnus-style chip-RAM strobes (`DRA` row/column multiplexing, `RAS0n`/`RAS1n`, `CASLn`/`CASUn`, `AWEn`, `DBRn`). It also issues RAS-only refresh cycles. It drives the SDRAM controller's Agnus-facing inputs during bring-up and in-system emulation, and can stand in for a missing Agnus on the chip-RAM bus. All timing is counted in `CLK80` cycles of 12.5 ns.

## Interface
- `T_ASR`, default 1: cycles from row address valid to RAS assert; must be ≥1.
- `T_RCD`, default 4: cycles from RAS assert to CAS assert; must be ≥3.
- `T_CAS`, default 8: CAS low width in cycles; must be ≥1.
- `T_RP`, default 6: precharge cycles after RAS deassert; must be ≥1.
- `AGNUS_2MB`, default 0: 1 selects 8375 multiplexing (`DRA[9]` used, `RAS0n` only); 0 selects 8372A multiplexing (`DRA[9]`=0, `A19` selects RAS).
- `CLK80`  in  1  system clock; all logic on its rising edge.
- `REFRESH_RST`  in  1  reset, asynchronous, active-high.
- `REQ_VALID`  in  1  request present.
- `REQ_READY`  out  1  high only in IDLE.
- `REQ_A`  in  20  word address `A[20:1]`.
- `REQ_WRITE`  in  1  1 = write cycle.
- `REQ_UDS`, `REQ_LDS`  in  1 each  byte enables (D15-8, D7-0).
- `REQ_REFRESH`  in  1  1 = RAS-only refresh; address and enables are ignored.
- `DONE`  out  1  one-cycle pulse at the end of the RAS phase.
- `DRA`  out  10  multiplexed DRAM address.
- `RAS0n`, `RAS1n`, `CASLn`, `CASUn`, `AWEn`, `DBRn`  out  1 each  active-low strobes.

## Operation
- Reset values: all strobes 1, `DRA`=0, `DONE`=0, state IDLE (`REQ_READY`=1).
- Acceptance: the request is accepted on the edge where `REQ_VALID && REQ_READY`. All request fields are captured on that edge and held for the whole cycle.
- Address mux:
  - Row = {`AGNUS_2MB` ? A19 : 0, A17..A9}.
  - Column = {`AGNUS_2MB` ? A20 : 0, A18, A8..A1}.
- RAS select:
  - 2MB mode: `RAS0n` only.
  - 1MB mode: A19=0 selects `RAS0n`; A19=1 selects `RAS1n`.
  - Refresh, either mode: both RAS lines low.
- State machine, with counter t=0 on the first cycle after acceptance:
  - IDLE → ADDR: `DBRn`=0, `DRA`=row, `AWEn`=~`REQ_WRITE` (refresh: `AWEn`=1).
  - ADDR → RAS at t=`T_ASR`: selected RAS lines go low.
  - RAS → CAS at t=`T_ASR`+`T_RCD`.
    - Column address: `DRA`=column from t=`T_ASR`+2; refresh keeps the row.
    - CAS strobes: `CASUn`=~UDS and `CASLn`=~LDS go low; refresh asserts no CAS.
  - CAS → PRE at t=`T_ASR`+`T_RCD`+`T_CAS`:
    - RAS, CAS, `AWEn`, `DBRn` return to 1 and `DONE` pulses.
    - `DRA` holds its last value.
  - PRE → IDLE after `T_RP` cycles.
- Both byte enables 0 on a non-refresh request: the full cycle runs with no CAS asserted, and `DONE` still pulses.
- `REFRESH_RST` mid-cycle: strobes deassert immediately and the state returns to IDLE. The request is dropped with no `DONE`.
- Counter is 8 bits. Parameter sums above 255 are illegal and are checked by an elaboration assertion.

## Timing
- Default cycle: accept edge, then 19 busy cycles (1+4+8+6). `REQ_READY` rises on the 20th cycle after acceptance.
- Back-to-back: with `REQ_VALID` held high, the next acceptance happens on the first edge with `REQ_READY`=1, giving a 20-cycle period.
- All outputs are registered. There is no combinational path from `REQ_*` to the strobes.
- Edge order: `DBRn` falls with the row address, `T_ASR` cycles before RAS. `DBRn` rises on the same edge as RAS.

## Structure
- Package `agnus_dram_pkg` holds:
  - the state enum (IDLE, ADDR, RAS, CAS, PRE);
  - the default timing constants;
  - the `row_addr()` and `col_addr()` functions, shared with verification models.
- Sub-module `agnus_addr_mux`: a combinational row/column/RAS-select decode from `REQ_A`, `AGNUS_2MB` and `REQ_REFRESH`.

## Test plan
- Reset, then no request: all strobes 1, `DRA`=0, `REQ_READY`=1 indefinitely.
- 2MB mode, write to `REQ_A` with A20=0, A19=1, A18=1, A17..9=9'h155, A8..1=8'hA5, UDS=LDS=1:
  - `DRA`=10'h355 at t=0, `RAS0n` low at t=1, `DRA`=10'h1A5 at t=3;
  - both CAS low t=5..12, `AWEn` low t=0..12, `DONE` at t=13, `REQ_READY` back at t=19.
- 1MB mode, same address, read, LDS only:
  - `DRA` row=10'h155, `RAS1n` low and `RAS0n` high;
  - `CASLn` low and `CASUn` high, `AWEn`=1 throughout.
- Refresh request: both RAS low t=1..12, no CAS, `DRA` holds row, `DONE` at t=13.
- `REQ_VALID` held high for two requests: second acceptance exactly 20 cycles after the first, with no overlap of RAS.
- `REFRESH_RST` pulsed at t=7 of a write: all strobes 1 within the same cycle, no `DONE`, `REQ_READY`=1 after release.
